// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the delay-line sample buffer.
package delay_line_pkg;

    // Upper bound on the number of read taps per sample.
    localparam int MAX_TAPS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Low bit of field k in a packed bus of w-bit fields.
    function automatic int tap_slice(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/spram_1rw_sync.sv
// Single-port synchronous RAM, one access per cycle, 1-cycle read latency.
// Behavioural model that stands in for the hardened macro.
module spram_1rw_sync #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write on ce&we, otherwise a read that lands on dout after the edge.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) mem[addr] <= din;
            else    dout      <= mem[addr];
        end
    end

endmodule

// File: rtl/delay_line_buffer.sv
// Circular sample buffer with NUM_TAPS programmable-delay read taps.
// Each accepted sample is written once, then every tap is read back in turn;
// taps reaching further back than the stored history return zero.
module delay_line_buffer
    import delay_line_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14,
    parameter int NUM_TAPS   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic [NUM_TAPS*ADDR_WIDTH-1:0] tap_delay,
    input  logic                           clear,
    output logic                           out_valid,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] tap_data,
    output logic [ADDR_WIDTH:0]            fill_level
);

    localparam int                  RAM_DEPTH = 2**ADDR_WIDTH;
    localparam int                  TIDX_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [ADDR_WIDTH:0] FULL      = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [TIDX_W-1:0]   LAST_TAP  = TIDX_W'(NUM_TAPS - 1);

    state_t                                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]                  wr_ptr, base_ptr;
    logic [DATA_WIDTH-1:0]                  data_q;
    logic [NUM_TAPS-1:0][ADDR_WIDTH-1:0]    delay_in, delay_q;
    logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]    tap_q;
    logic [TIDX_W-1:0]                      tap_idx, rd_idx;
    logic                                   rd_pend;
    logic                                   accept;
    logic                                   ram_ce, ram_we;
    logic [ADDR_WIDTH-1:0]                  ram_addr;
    logic [DATA_WIDTH-1:0]                  ram_dout;

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        assign delay_in[k] = tap_delay[tap_slice(k, ADDR_WIDTH) +: ADDR_WIDTH];
        assign tap_data[tap_slice(k, DATA_WIDTH) +: DATA_WIDTH] = tap_q[k];
    end

    assign accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: one write, NUM_TAPS reads, one cycle to drain the last read.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = WRITE;
            WRITE:   state_nxt = READ;
            READ:    if (tap_idx == LAST_TAP) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs and RAM control; clear masks in_ready so it always beats in_valid.
    always_comb begin
        in_ready  = rst_n && (state == IDLE) && !clear;
        out_valid = (state == DONE);
        ram_ce    = (state == WRITE) || (state == READ);
        ram_we    = (state == WRITE);
        ram_addr  = (state == WRITE) ? wr_ptr : base_ptr - delay_q[tap_idx];
    end

    // Datapath: capture at acceptance, pointer/fill update, tap capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            base_ptr   <= '0;
            fill_level <= '0;
            data_q     <= '0;
            delay_q    <= '0;
            tap_q      <= '0;
            tap_idx    <= '0;
            rd_idx     <= '0;
            rd_pend    <= 1'b0;
        end else begin
            rd_pend <= 1'b0;
            // Read data is one cycle behind its issue; fill_level is already post-write here.
            if (rd_pend)
                tap_q[rd_idx] <= ({1'b0, delay_q[rd_idx]} >= fill_level) ? '0 : ram_dout;
            case (state)
                IDLE: begin
                    if (clear) begin
                        wr_ptr     <= '0;
                        fill_level <= '0;
                    end else if (accept) begin
                        data_q  <= in_data;
                        delay_q <= delay_in;
                    end
                end
                WRITE: begin
                    base_ptr <= wr_ptr;
                    wr_ptr   <= wr_ptr + 1'b1;
                    if (fill_level != FULL) fill_level <= fill_level + 1'b1;
                    tap_idx  <= '0;
                end
                READ: begin
                    rd_pend <= 1'b1;
                    rd_idx  <= tap_idx;
                    tap_idx <= tap_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    spram_1rw_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .ce   (ram_ce),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (data_q),
        .dout (ram_dout)
    );

endmodule

// File: tb/tb_delay_line_buffer.sv
// Scoreboard bench for delay_line_buffer: a small (AW=4, 2 taps) and a
// wide (AW=6, 8 taps) instance driven from directed vectors.
module tb_delay_line_buffer;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: ADDR_WIDTH=4, NUM_TAPS=2
    logic        a_in_valid, a_in_ready, a_clear, a_out_valid;
    logic [15:0] a_in_data;
    logic [7:0]  a_tap_delay;
    logic [31:0] a_tap_data;
    logic [4:0]  a_fill;

    // Instance B: ADDR_WIDTH=6, NUM_TAPS=8
    logic         b_in_valid, b_in_ready, b_clear, b_out_valid;
    logic [15:0]  b_in_data;
    logic [47:0]  b_tap_delay;
    logic [127:0] b_tap_data;
    logic [6:0]   b_fill;

    delay_line_buffer #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .NUM_TAPS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .tap_delay(a_tap_delay), .clear(a_clear),
        .out_valid(a_out_valid), .tap_data(a_tap_data), .fill_level(a_fill));

    delay_line_buffer #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .NUM_TAPS(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .tap_delay(b_tap_delay), .clear(b_clear),
        .out_valid(b_out_valid), .tap_data(b_tap_data), .fill_level(b_fill));

    typedef struct packed {
        logic [31:0] taps;
        logic [4:0]  fill;
        int          acc;
    } exp_a_t;

    typedef struct packed {
        logic [127:0] taps;
        logic [6:0]   fill;
        int           acc;
    } exp_b_t;

    exp_a_t qa[$];
    exp_b_t qb[$];
    exp_a_t ea;
    exp_b_t eb;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor A: every out_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (a_out_valid === 1'b1) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_out_valid got=1 expected=0 at cyc %0d", cyc);
            end else begin
                ea = qa.pop_front();
                chk("a_tap0", 128'(a_tap_data[15:0]), 128'(ea.taps[15:0]));
                chk("a_tap1", 128'(a_tap_data[31:16]), 128'(ea.taps[31:16]));
                chk("a_fill", 128'(a_fill), 128'(ea.fill));
                chk("a_latency", 128'(cyc - ea.acc + 1), 128'(5));
            end
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        if (b_out_valid === 1'b1) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_out_valid got=1 expected=0 at cyc %0d", cyc);
            end else begin
                eb = qb.pop_front();
                chk("b_taps", b_tap_data, eb.taps);
                chk("b_fill", 128'(b_fill), 128'(eb.fill));
                chk("b_latency", 128'(cyc - eb.acc + 1), 128'(11));
            end
        end
    end

    task automatic push_a(input logic [15:0] d, input logic [3:0] d0, input logic [3:0] d1,
                          input bit exp_en, input logic [15:0] e0, input logic [15:0] e1,
                          input logic [4:0] ef);
        int n;
        exp_a_t e;
        n = 0;
        @(negedge clk);
        while (a_in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (a_in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL a_ready_timeout got=0 expected=1");
            return;
        end
        a_in_valid  = 1'b1;
        a_in_data   = d;
        a_tap_delay = {d1, d0};
        @(posedge clk); #1;
        a_in_valid  = 1'b0;
        a_in_data   = 16'hDEAD;
        a_tap_delay = 8'hFF;  // must not affect the sample in flight
        if (exp_en) begin
            e.taps = {e1, e0};
            e.fill = ef;
            e.acc  = cyc;
            qa.push_back(e);
            n = 0;
            @(negedge clk);
            while (a_in_ready !== 1'b1 && n < 50) begin n++; @(negedge clk); end
            chk("a_busy_cycles", 128'(n), 128'(5));
        end
    endtask

    task automatic push_b(input logic [15:0] d, input logic [47:0] dl,
                          input logic [127:0] et, input logic [6:0] ef);
        int n;
        exp_b_t e;
        n = 0;
        @(negedge clk);
        while (b_in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (b_in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL b_ready_timeout got=0 expected=1");
            return;
        end
        b_in_valid  = 1'b1;
        b_in_data   = d;
        b_tap_delay = dl;
        @(posedge clk); #1;
        b_in_valid  = 1'b0;
        b_in_data   = 16'hDEAD;
        b_tap_delay = '1;
        e.taps = et;
        e.fill = ef;
        e.acc  = cyc;
        qb.push_back(e);
        n = 0;
        @(negedge clk);
        while (b_in_ready !== 1'b1 && n < 50) begin n++; @(negedge clk); end
        chk("b_busy_cycles", 128'(n), 128'(11));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] et;
        logic [47:0]  dl;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_tap_delay = '0; a_clear = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_tap_delay = '0; b_clear = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_in_ready", 128'(a_in_ready), 128'(0));
        chk("rst_a_out_valid", 128'(a_out_valid), 128'(0));
        chk("rst_a_tap_data", 128'(a_tap_data), 128'(0));
        chk("rst_a_fill", 128'(a_fill), 128'(0));
        chk("rst_b_tap_data", b_tap_data, 128'(0));
        chk("rst_b_fill", 128'(b_fill), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_a_ready_after_release", 128'(a_in_ready), 128'(1));

        // Single sample, delay 3 reaches past the history.
        push_a(16'h1234, 4'd0, 4'd3, 1'b1, 16'h1234, 16'h0000, 5'd1);

        // Five pushes from a fresh buffer.
        do_reset();
        for (int v = 1; v <= 4; v++)
            push_a(16'(v), 4'd0, 4'd0, 1'b1, 16'(v), 16'(v), 5'(v));
        push_a(16'h0005, 4'd1, 4'd4, 1'b1, 16'h0004, 16'h0001, 5'd5);

        // Wrap-around with saturated fill.
        do_reset();
        for (int v = 1; v <= 19; v++)
            push_a(16'(v), 4'd0, 4'd0, 1'b1, 16'(v), 16'(v), (v > 16) ? 5'd16 : 5'(v));
        push_a(16'd20, 4'd15, 4'd0, 1'b1, 16'd5, 16'd20, 5'd16);

        // clear collides with in_valid in IDLE: clear wins.
        a_clear = 1'b1; a_in_valid = 1'b1; a_in_data = 16'hBEEF;
        #1;
        chk("clear_in_ready", 128'(a_in_ready), 128'(0));
        @(negedge clk);
        a_clear = 1'b0; a_in_valid = 1'b0;
        #1;
        chk("clear_fill", 128'(a_fill), 128'(0));
        chk("clear_not_accepted", 128'(a_in_ready), 128'(1));
        push_a(16'hAAAA, 4'd0, 4'd1, 1'b1, 16'hAAAA, 16'h0000, 5'd1);

        // Reset during READ aborts the sample in flight.
        push_a(16'h5555, 4'd0, 4'd0, 1'b0, 16'h0, 16'h0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_in_ready", 128'(a_in_ready), 128'(0));
        chk("midrst_tap_data", 128'(a_tap_data), 128'(0));
        chk("midrst_fill", 128'(a_fill), 128'(0));
        chk("midrst_out_valid", 128'(a_out_valid), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after_release", 128'(a_in_ready), 128'(1));
        repeat (10) @(negedge clk);

        // Wide instance: 64 samples, eight taps on the last.
        for (int v = 0; v < 63; v++) begin
            et = '0;
            for (int k = 0; k < 8; k++) et[k*16 +: 16] = 16'(v);
            push_b(16'(v), 48'd0, et, 7'(v + 1));
        end
        et = '0;
        dl = '0;
        for (int k = 0; k < 8; k++) begin
            et[k*16 +: 16] = 16'(63 - k);
            dl[k*6 +: 6]   = 6'(k);
        end
        push_b(16'd63, dl, et, 7'd64);

        repeat (5) @(negedge clk);
        chk("a_queue_drained", 128'(qa.size()), 128'(0));
        chk("b_queue_drained", 128'(qb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
